// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Sequences a WIDTH-bit add through an external 4-bit adder, one nibble
//   per cycle, LSB nibble first. The carry is chained through carry_reg.
//
//   state | meaning
//   IDLE  | ready for operands (in_ready=1)
//   RUN   | driving nibble idx to the adder, capturing its sum and carry
//   DONE  | result held on out_* until out_ready
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       operand handshake (in_a, in_b, in_cin)
//   add_a/add_b/add_cin     nibble operands to the external adder
//   add_sum/add_cout        combinational return from the external adder
//   out_valid/out_ready     result handshake (out_sum, out_cout, out_ovf)
//
// Configuration macro: NIBBLE_SERIAL_ADDER_OVF_EN
//   defined   -> out_ovf reports signed overflow with the result
//   undefined -> out_ovf is tied to 0
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, result;
  logic             carry_reg;
  logic [IW-1:0]    idx;
  logic             accept;
  logic             last;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_sum   = '0;
    out_cout  = 1'b0;
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        add_a   = a_reg[4*idx +: 4];
        add_b   = b_reg[4*idx +: 4];
        add_cin = carry_reg;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        out_sum   = result;
        out_cout  = carry_reg;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      result    <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
    end else if (accept) begin
      a_reg     <= in_a;
      b_reg     <= in_b;
      carry_reg <= in_cin;
      result    <= '0;
      idx       <= '0;
    end else if (state == RUN) begin
      result[4*idx +: 4] <= add_sum;
      carry_reg          <= add_cout;
      // idx parks at the last nibble; it is cleared on the next accept
      if (!last) idx <= idx + 1'b1;
    end
  end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic ovf_reg;

  // a^b^sum at the MSB recovers the carry into the MSB; xor with the
  // carry out of the MSB gives two's-complement overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    ovf_reg <= 1'b0;
    else if (accept)               ovf_reg <= 1'b0;
    else if (state == RUN && last) ovf_reg <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1]
                                              ^ add_sum[3] ^ add_cout;
  end

  assign out_ovf = (state == DONE) && ovf_reg;
`else
  assign out_ovf = 1'b0;
`endif

endmodule
